// File: rtl/route_edge_scheduler.sv
// Edge scheduler: queues routing edges, issues them one at a time to a routing engine and tallies results.
// Define ROUTE_RETRY_EN to re-queue failed edges up to MAX_RETRY times before counting them as failed.
module route_edge_scheduler #(
    parameter int EDGE_W    = 8,
    parameter int DEPTH     = 16,
    parameter int MAX_RETRY = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       edge_in_valid,
    input  logic [EDGE_W-1:0]          edge_in,
    output logic                       edge_in_ready,
    input  logic                       start,
    output logic                       rt_valid,
    output logic [EDGE_W-1:0]          rt_edge,
    input  logic                       rt_ready,
    input  logic                       res_valid,
    input  logic                       res_ok,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     routed_cnt,
    output logic [$clog2(DEPTH):0]     failed_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   head, tail;
    logic [CW-1:0]   count;
    logic [EDGE_W-1:0] q_edge [DEPTH];

    logic            push_en, pop_en, routed_inc, failed_inc, clear_cnt;
    logic [EDGE_W-1:0] push_edge;

`ifdef ROUTE_RETRY_EN
    localparam logic [1:0] MAX_R = 2'(MAX_RETRY);
    logic [1:0]        q_retry [DEPTH];
    logic [EDGE_W-1:0] cur_edge;
    logic [1:0]        cur_retry;
    logic [1:0]        push_retry;
`endif

    assign rt_edge = q_edge[head];

    always_comb begin
        state_n       = state;
        push_en       = 1'b0;
        pop_en        = 1'b0;
        routed_inc    = 1'b0;
        failed_inc    = 1'b0;
        clear_cnt     = 1'b0;
        push_edge     = edge_in;
`ifdef ROUTE_RETRY_EN
        push_retry    = 2'd0;
`endif
        edge_in_ready = 1'b0;
        rt_valid      = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                edge_in_ready = (count != FULL);
                push_en       = edge_in_valid && (count != FULL);
                if (start) begin
                    clear_cnt = 1'b1;
                    state_n   = ((count != '0) || push_en) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                rt_valid = 1'b1;
                busy     = 1'b1;
                if (rt_ready) begin
                    pop_en  = 1'b1;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (res_valid) begin
                    if (res_ok) begin
                        routed_inc = 1'b1;
                    end else begin
`ifdef ROUTE_RETRY_EN
                        // A failed edge goes to the back of the queue while it still has retries left.
                        if (cur_retry < MAX_R) begin
                            push_en    = 1'b1;
                            push_edge  = cur_edge;
                            push_retry = cur_retry + 2'd1;
                        end else begin
                            failed_inc = 1'b1;
                        end
`else
                        failed_inc = 1'b1;
`endif
                    end
                    state_n = ((count != '0) || push_en) ? ISSUE : DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            routed_cnt <= '0;
            failed_cnt <= '0;
        end else begin
            state <= state_n;
            if (push_en) tail <= tail + 1'b1;
            if (pop_en)  head <= head + 1'b1;
            if (push_en && !pop_en)
                count <= count + 1'b1;
            else if (pop_en && !push_en)
                count <= count - 1'b1;
            if (clear_cnt) begin
                routed_cnt <= '0;
                failed_cnt <= '0;
            end else begin
                if (routed_inc) routed_cnt <= routed_cnt + 1'b1;
                if (failed_inc) failed_cnt <= failed_cnt + 1'b1;
            end
        end
    end

    // Queue storage is deliberately left unreset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_en) begin
            q_edge[tail] <= push_edge;
`ifdef ROUTE_RETRY_EN
            q_retry[tail] <= push_retry;
`endif
        end
`ifdef ROUTE_RETRY_EN
        if (pop_en) begin
            cur_edge  <= q_edge[head];
            cur_retry <= q_retry[head];
        end
`endif
    end

endmodule

// File: tb/tb_route_edge_scheduler.sv
// Scoreboard bench for route_edge_scheduler: a queue-level reference model predicts issue order and final counts.
module tb_route_edge_scheduler;

    localparam int EDGE_W    = 8;
    localparam int DEPTH     = 16;
    localparam int MAX_RETRY = 2;
    localparam int CW        = $clog2(DEPTH) + 1;
`ifdef ROUTE_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset, edge_in_valid, edge_in_ready, start;
    logic [EDGE_W-1:0] edge_in, rt_edge;
    logic              rt_valid, rt_ready, res_valid, res_ok, busy, done;
    logic [CW-1:0]     routed_cnt, failed_cnt;

    route_edge_scheduler #(.EDGE_W(EDGE_W), .DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .reset(reset),
        .edge_in_valid(edge_in_valid), .edge_in(edge_in), .edge_in_ready(edge_in_ready),
        .start(start),
        .rt_valid(rt_valid), .rt_edge(rt_edge), .rt_ready(rt_ready),
        .res_valid(res_valid), .res_ok(res_ok),
        .busy(busy), .done(done), .routed_cnt(routed_cnt), .failed_cnt(failed_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] e; logic [7:0] r; } ent_t;
    typedef struct packed { logic [CW-1:0] routed; logic [CW-1:0] failed; } res_t;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [EDGE_W-1:0] exp_issue [$];
    res_t              exp_res   [$];
    logic [EDGE_W-1:0] load_list [$];
    logic [EDGE_W-1:0] fail_set  [$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_fail(input logic [EDGE_W-1:0] e);
        foreach (fail_set[i]) if (fail_set[i] == e) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: plain FIFO of (edge, retries) drained until empty.
    task automatic buildModel(output int n_issue);
        ent_t q [$];
        ent_t x;
        int routed = 0;
        int failed = 0;
        n_issue = 0;
        foreach (load_list[i]) q.push_back('{e: load_list[i], r: 8'd0});
        while (q.size() > 0) begin
            x = q.pop_front();
            exp_issue.push_back(x.e);
            n_issue++;
            if (!is_fail(x.e)) routed++;
            else if (RETRY_EN && (int'(x.r) < MAX_RETRY)) q.push_back('{e: x.e, r: x.r + 8'd1});
            else failed++;
        end
        exp_res.push_back('{routed: CW'(routed), failed: CW'(failed)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        edge_in_valid = 0; start = 0; rt_ready = 0; res_valid = 0; res_ok = 0;
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic applyStimulus(input int stall_min, input int stall_max, input int delay_max, input bit same_cycle);
        int n_issue, k, n;
        logic [EDGE_W-1:0] e;
        doReset();
        buildModel(n_issue);
        for (int i = 0; i < load_list.size(); i++) begin
            checkOutput("in_ready_idle", edge_in_ready, 1);
            edge_in_valid = 1;
            edge_in = load_list[i];
            if (same_cycle && i == load_list.size() - 1) start = 1;
            step();
        end
        edge_in_valid = 0;
        if (!start) begin
            start = 1;
            step();
        end
        start = 0;
        checkOutput("issue_latency", rt_valid, (load_list.size() > 0));
        if (load_list.size() == 0) checkOutput("empty_done", done, 1);
        for (int i = 0; i < n_issue; i++) begin
            k = 0;
            while (!rt_valid && k < 20) begin step(); k++; end
            if (!rt_valid) begin
                checkOutput("rt_valid_timeout", 0, 1);
                break;
            end
            checkOutput("busy_issue", busy, 1);
            n = $urandom_range(stall_max, stall_min);
            for (int s = 0; s < n; s++) begin
                rt_ready = 0;
                res_valid = 1'($urandom % 2);
                res_ok = 1'($urandom % 2);
                step();
            end
            res_valid = 0;
            rt_ready = 1;
            e = rt_edge;
            step();
            rt_ready = 0;
            n = $urandom_range(delay_max, 0);
            for (int d = 0; d < n; d++) begin
                start = 1'($urandom % 2);
                step();
            end
            start = 0;
            res_valid = 1;
            res_ok = !is_fail(e);
            step();
            res_valid = 0;
        end
        k = 0;
        while (!done && k < 20) begin step(); k++; end
        if (!done) begin
            checkOutput("done_timeout", 0, 1);
            exp_issue.delete();
            exp_res.delete();
        end
        step();
        checkOutput("idle_after_done", {busy, done, rt_valid}, 0);
        checkOutput("scoreboard_drained", exp_issue.size() + exp_res.size(), 0);
    endtask

    task automatic fullAndReset();
        doReset();
        load_list.delete();
        for (int i = 0; i < DEPTH; i++) load_list.push_back(EDGE_W'($urandom));
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("in_ready_fill", edge_in_ready, 1);
            edge_in_valid = 1;
            edge_in = load_list[i];
            step();
        end
        edge_in_valid = 0;
        checkOutput("full_not_ready", edge_in_ready, 0);
        edge_in_valid = 1;
        edge_in = 8'hEE;
        step();
        edge_in_valid = 0;
        checkOutput("still_full", edge_in_ready, 0);
        exp_issue.push_back(load_list[0]);
        start = 1;
        step();
        start = 0;
        rt_ready = 1;
        step();
        rt_ready = 0;
        checkOutput("busy_wait", busy, 1);
        reset = 1;
        step();
        reset = 0;
        checkOutput("reset_mid_run", {busy, rt_valid, done, edge_in_ready}, 4'b0001);
        res_valid = 1;
        res_ok = 1;
        step();
        res_valid = 0;
        checkOutput("late_result_ignored", {busy, rt_valid, done}, 0);
        exp_res.push_back('{routed: '0, failed: '0});
        start = 1;
        step();
        start = 0;
        checkOutput("queue_cleared_done", done, 1);
        checkOutput("queue_cleared_no_issue", rt_valid, 0);
        step();
        checkOutput("scoreboard_drained_full", exp_issue.size() + exp_res.size(), 0);
    endtask

    // Monitor: pops the scoreboard on every issue handshake and every done pulse.
    logic              prev_stall = 1'b0;
    logic              prev_done  = 1'b0;
    logic [EDGE_W-1:0] prev_edge  = '0;
    always @(negedge clk) begin
        res_t r;
        if (reset) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (rt_valid && prev_stall) checkOutput("rt_edge_stable", rt_edge, prev_edge);
            if (rt_valid && rt_ready) begin
                if (exp_issue.size() == 0) checkOutput("unexpected_issue", rt_edge, 32'hFFFF_FFFF);
                else checkOutput("issue_order", rt_edge, exp_issue.pop_front());
            end
            if (done) begin
                checkOutput("done_one_cycle", prev_done, 0);
                checkOutput("busy_in_done", busy, 0);
                if (exp_res.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    r = exp_res.pop_front();
                    checkOutput("routed_cnt", routed_cnt, r.routed);
                    checkOutput("failed_cnt", failed_cnt, r.failed);
                end
            end
            prev_stall = rt_valid && !rt_ready;
            prev_edge  = rt_edge;
            prev_done  = done;
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        edge_in = '0;
        doReset();
        step();
        checkOutput("reset_state", {busy, done, rt_valid, edge_in_ready}, 4'b0001);
        checkOutput("reset_counters", {routed_cnt, failed_cnt}, 0);

        $display("[TB] three edges, all routed");
        load_list = '{8'h12, 8'h34, 8'h56};
        fail_set.delete();
        applyStimulus(0, 0, 0, 1'b0);

        $display("[TB] empty queue start");
        load_list.delete();
        applyStimulus(0, 0, 0, 1'b0);

        $display("[TB] 0x12 always fails");
        load_list = '{8'h12, 8'h34};
        fail_set = '{8'h12};
        applyStimulus(0, 0, 1, 1'b0);

        $display("[TB] engine stalls five cycles");
        load_list = '{8'hA5, 8'h3C};
        fail_set.delete();
        applyStimulus(5, 5, 2, 1'b1);

        $display("[TB] fill to depth, reset during wait");
        fullAndReset();

        $display("[TB] randomized runs");
        for (int run = 0; run < 25; run++) begin
            int n;
            n = $urandom_range(DEPTH, 1);
            load_list.delete();
            fail_set.delete();
            for (int i = 0; i < n; i++) begin
                load_list.push_back(EDGE_W'($urandom));
                if ($urandom_range(9, 0) < 3) fail_set.push_back(load_list[i]);
            end
            applyStimulus(0, 3, 3, 1'($urandom % 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/route_edge_scheduler.md
ROUTE_EDGE_SCHEDULER -- requirements
Module: route_edge_scheduler

Interface
REQ-001 SHALL have parameter EDGE_W, default 8, edge word width (src cell [7:4], dst cell [3:0]).
REQ-002 SHALL have parameter DEPTH, default 16, edge queue entries (power of two).
REQ-003 SHALL have parameter MAX_RETRY, default 2, re-issues allowed per failed edge.
REQ-004 SHALL have clk  input  1  rising-edge clock.
REQ-005 SHALL have reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have edge_in_valid  input  1, edge_in  input  EDGE_W, edge_in_ready  output  1: edge load handshake.
REQ-007 SHALL have start  input  1  begin routing run over queued edges.
REQ-008 SHALL have rt_valid  output  1, rt_edge  output  EDGE_W, rt_ready  input  1: issue to routing engine.
REQ-009 SHALL have res_valid  input  1, res_ok  input  1: engine result (1 = routed, 0 = blacklisted).
REQ-010 SHALL have busy  output  1, done  output  1, routed_cnt  output  $clog2(DEPTH)+1, failed_cnt  output  $clog2(DEPTH)+1.

Function
REQ-011 SHALL hold edges in a circular queue (head, tail, count), each entry = edge word + 2-bit retry count; retry count 0 on load.
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-013 SHALL assert edge_in_ready only in IDLE with count < DEPTH; push on edge_in_valid && edge_in_ready.
REQ-014 SHALL, in IDLE on start, clear routed_cnt/failed_cnt and go to ISSUE if post-load count > 0, else to DONE; a same-cycle load is included in the run.
REQ-015 SHALL, in ISSUE, drive rt_valid=1 and rt_edge=head edge; on rt_ready pop head and go to WAIT; rt_edge stable while rt_valid && !rt_ready.
REQ-016 SHALL, in WAIT, on res_valid: res_ok=1 increments routed_cnt; res_ok=0 handled per REQ-026/027.
REQ-017 SHALL, after a result, go to ISSUE if count > 0 (after any re-push), else DONE.
REQ-018 SHALL ignore res_valid outside WAIT and start outside IDLE.
REQ-019 SHALL assert done for exactly one cycle in DONE, then return to IDLE; counters hold until next start.
REQ-020 SHALL assert busy in ISSUE and WAIT only.
REQ-021 SHALL have issue latency of one cycle: start at cycle N gives rt_valid at N+1.
REQ-022 SHALL wrap head/tail modulo DEPTH; full push (count == DEPTH) never occurs, since re-push follows a pop.

Reset
REQ-023 SHALL on reset: state IDLE, head=tail=count=0, counters 0, rt_valid=0, done=0, busy=0, edge_in_ready=1 (next cycle).
REQ-024 SHALL, on reset mid-run, discard in-flight edge and queue; a later res_valid is ignored.
REQ-025 SHALL leave queue data contents unreset (only pointers reset).

Configuration
REQ-026 SHALL, with ROUTE_RETRY_EN defined, re-push a failed edge at tail with retry+1 if retry < MAX_RETRY, else increment failed_cnt.
REQ-027 SHALL, without ROUTE_RETRY_EN, increment failed_cnt on every res_ok=0 and never re-push; retry field may be omitted.

Verification
REQ-028 SHALL test: load 0x12,0x34,0x56, start, engine always ready, all res_ok=1 -> three issues in order, routed_cnt=3, failed_cnt=0, one-cycle done.
REQ-029 SHALL test: start with empty queue -> done one cycle after start, counters 0, no rt_valid.
REQ-030 SHALL test: with ROUTE_RETRY_EN, load 0x12,0x34; 0x12 always fails -> issue order 12,34,12,12; routed_cnt=1, failed_cnt=1; without macro order 12,34, failed_cnt=1.
REQ-031 SHALL test: rt_ready held low 5 cycles -> rt_valid and rt_edge stable; spurious res_valid in ISSUE ignored.
REQ-032 SHALL test: load 16 edges -> edge_in_ready low after 16th; reset during WAIT -> IDLE, count 0, busy 0 next cycle.
